pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Owns the IF/ID pipeline register and sequences the decode stage of the core.
- Holds the fetched instruction and address and presents them to the combinational decoder; decode returns the rs1/rs2 read addresses.
- Tracks long-latency destination registers in a scoreboard and stalls decode on RAW hazards.
- Drops the ID slot and discards fetch for a configurable window after a jump/branch redirect.

Parameters:
- FLUSH_CYCLES, 1, cycles of fetch discard after jump_i (legal range 1..15).
- STALL_CNT_W, 32, width of the saturating hazard-stall counter.

Ports:
- clk  input  1  core clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- if_valid_i  input  1  fetch presents a valid instruction.
- if_ready_o  output  1  controller accepts the fetch word this cycle.
- ins_i  input  32  fetched instruction.
- ins_addr_i  input  32  fetched instruction address.
- id_valid_o  output  1  ID slot holds a live instruction.
- id_ins_o  output  32  ID-slot instruction, to decode.
- id_ins_addr_o  output  32  ID-slot address, to decode.
- rs1_addr_i  input  5  rs1 read address returned by decode.
- rs2_addr_i  input  5  rs2 read address returned by decode.
- ex_ready_i  input  1  execute can accept an instruction.
- issue_o  output  1  ID instruction transfers to execute this cycle.
- wb_valid_i  input  1  long-latency result written back.
- wb_rd_i  input  5  destination of that write-back.
- jump_i  input  1  execute redirects the PC this cycle.
- busy_o  output  32  scoreboard vector, bit n = xn pending.
- state_o  output  2  FSM state: 0 RUN, 1 STALL, 2 FLUSH.
- stall_cnt_o  output  STALL_CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset values:
  - id_valid_o=0
  - id_ins_o=32'h00000013 (NOP)
  - id_ins_addr_o=0
  - busy_o=0
  - state=RUN
  - flush counter=0
  - stall_cnt_o=0
- hazard = id_valid_o & ((rs1_addr_i!=0 & busy[rs1_addr_i]) | (rs2_addr_i!=0 & busy[rs2_addr_i])).
  - x0 never causes a hazard.
  - A wb clear in the same cycle does not unblock; the stall releases the following cycle (no bypass).
- issue_o = id_valid_o & ex_ready_i & ~hazard & ~jump_i (combinational).
- Long-latency detection is internal, from id_ins_o:
  - opcode 7'b0000011 (load), or
  - opcode 7'b0110011 with func7=7'b0000001 and func3[2]=1 (div/rem).
- rd = id_ins_o[11:7].
- Scoreboard:
  - On issue_o & long & rd!=0, set busy[rd].
  - On wb_valid_i, clear busy[wb_rd_i].
  - If both hit the same register in one cycle, set wins.
  - busy[0] is always 0.
  - jump_i does not clear the scoreboard; in-flight results still write back.
- if_ready_o:
  - RUN/STALL: ~id_valid_o | issue_o.
  - FLUSH, or jump_i asserted: 1 (word consumed and dropped).
- IF/ID register:
  - Load: if_valid_i & if_ready_o & ~jump_i & state!=FLUSH loads ins_i/ins_addr_i and sets id_valid_o=1 next cycle.
  - Drain: issue_o without a new load clears id_valid_o.
  - Hold: otherwise hold contents; id_ins_o keeps its last value when invalid.
- FSM (jump_i has top priority from any state):
  - RUN -> STALL: id_valid_o & ~issue_o & ~jump_i.
  - STALL -> RUN: issue_o.
  - any -> FLUSH: jump_i. Next cycle id_valid_o=0; flush counter loads FLUSH_CYCLES-1.
  - FLUSH: counter decrements each cycle. Exit to RUN on the cycle the counter equals 0; that cycle still discards.
  - jump_i while in FLUSH reloads the counter.
- stall_cnt_o increments by 1 on every cycle where hazard=1 and saturates at all-ones.
- Stalls caused only by ex_ready_i=0 are not counted.
- Reset mid-stall or mid-flush: all state returns to reset values immediately (async).

Decomposition:
- Shared package (ins_defines.v): `INST_TYPE_L, `INST_TYPE_R_M, `INST_NOP (32'h00000013), `x0, FSM state encodings PC_RUN/PC_STALL/PC_FLUSH.
- One natural sub-module: scoreboard (32-entry busy vector with set/clear ports and two combinational lookup ports), instantiated once.

Test Plan:
- Reset, then 4 back-to-back ALU words (addi x1..x4) with ex_ready_i=1:
  - one issue per cycle, latency 1 from if_valid_i to id_valid_o.
  - busy_o stays 0; stall_cnt_o=0.
- lw x5 issued, then add x6,x5,x1:
  - busy_o[5]=1 after the lw issues; add stalls, state=STALL.
  - wb_valid_i with wb_rd_i=5 after 3 cycles: add issues on the following cycle; stall_cnt_o=3.
- lw x0 then add x7,x0,x0: busy_o stays 0, no stall.
- div x8 issues in the same cycle that wb clears x8 from an earlier load: busy_o[8]=1 afterwards (set wins).
- FLUSH_CYCLES=2, jump_i while an instruction is in ID with if_valid_i=1 continuously:
  - id_valid_o=0 next cycle; state=FLUSH for 2 cycles; 2 fetch words dropped; third word enters ID.
  - Assert rst during FLUSH: outputs at reset values in the same cycle.
- ex_ready_i=0 for 5 cycles with a valid ALU instruction in ID:
  - if_ready_o=0, state=STALL, ID contents held.
  - stall_cnt_o unchanged; issue occurs when ex_ready_i returns.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, FSM encoding and ID-slot payload for the decode-stage controller.
package pipe_ctrl_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned REG_AW      = 5;
  localparam int unsigned NREGS       = 32;
  localparam int unsigned FLUSH_CNT_W = 4;

  localparam logic [6:0]        INST_TYPE_L   = 7'b0000011;
  localparam logic [6:0]        INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0]        FUNCT7_M      = 7'b0000001;
  localparam logic [XLEN-1:0]   INST_NOP      = 32'h00000013;
  localparam logic [REG_AW-1:0] X0            = 5'd0;

  typedef enum logic [1:0] {
    PC_RUN   = 2'd0,
    PC_STALL = 2'd1,
    PC_FLUSH = 2'd2
  } pc_state_e;

  typedef struct packed {
    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] addr;
  } id_slot_t;

  // Loads and div/rem (funct3[2] set within the M extension) complete out of order.
  function automatic logic is_long_latency(input logic [6:0] opcode,
                                           input logic [6:0] funct7,
                                           input logic       funct3_msb);
    return (opcode == INST_TYPE_L) ||
           ((opcode == INST_TYPE_R_M) && (funct7 == FUNCT7_M) && funct3_msb);
  endfunction

endpackage

// File: rtl/pipe_ctrl_scoreboard.sv
// Pending-destination tracker: one busy bit per architectural register, x0 pinned clear.
module pipe_ctrl_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_idx,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_idx,
  input  logic [REG_AW-1:0] rd1_idx,
  input  logic [REG_AW-1:0] rd2_idx,
  output logic              rd1_busy,
  output logic              rd2_busy,
  output logic [NREGS-1:0]  busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Clear applied before set so a same-register collision leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[X0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign rd1_busy = (rd1_idx != X0) & busy_q[rd1_idx];
  assign rd2_busy = (rd2_idx != X0) & busy_q[rd2_idx];
  assign busy     = busy_q;

endmodule

// File: rtl/pipe_ctrl.sv
// IF/ID pipeline register and decode sequencing: RAW hazard stalls against the
// long-latency scoreboard and fetch discard after a redirect.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned STALL_CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid_i,
  output logic                   if_ready_o,
  input  logic [XLEN-1:0]        ins_i,
  input  logic [XLEN-1:0]        ins_addr_i,
  output logic                   id_valid_o,
  output logic [XLEN-1:0]        id_ins_o,
  output logic [XLEN-1:0]        id_ins_addr_o,
  input  logic [REG_AW-1:0]      rs1_addr_i,
  input  logic [REG_AW-1:0]      rs2_addr_i,
  input  logic                   ex_ready_i,
  output logic                   issue_o,
  input  logic                   wb_valid_i,
  input  logic [REG_AW-1:0]      wb_rd_i,
  input  logic                   jump_i,
  output logic [NREGS-1:0]       busy_o,
  output logic [1:0]             state_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX  = {STALL_CNT_W{1'b1}};

  pc_state_e               state_q;
  pc_state_e               state_d;
  logic [FLUSH_CNT_W-1:0]  flush_cnt_q;
  logic [FLUSH_CNT_W-1:0]  flush_cnt_d;
  id_slot_t                slot_q;
  logic                    id_valid_q;
  logic [STALL_CNT_W-1:0]  stall_cnt_q;

  logic                    rs1_busy_c;
  logic                    rs2_busy_c;
  logic                    hazard_c;
  logic                    issue_c;
  logic                    if_ready_c;
  logic                    load_c;
  logic                    long_c;
  logic                    sb_set_c;
  logic [REG_AW-1:0]       rd_c;

  assign rd_c   = slot_q.ins[11:7];
  assign long_c = is_long_latency(slot_q.ins[6:0], slot_q.ins[31:25], slot_q.ins[14]);

  // Handshake and hazard decode; busy is the registered view, so a same-cycle wb cannot bypass.
  always_comb begin
    hazard_c   = id_valid_q & (rs1_busy_c | rs2_busy_c);
    issue_c    = id_valid_q & ex_ready_i & ~hazard_c & ~jump_i;
    if_ready_c = (state_q == PC_FLUSH) | jump_i | ~id_valid_q | issue_c;
    load_c     = if_valid_i & if_ready_c & ~jump_i & (state_q != PC_FLUSH);
    sb_set_c   = issue_c & long_c & (rd_c != X0);
  end

  pipe_ctrl_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (sb_set_c),
    .set_idx  (rd_c),
    .clr_en   (wb_valid_i),
    .clr_idx  (wb_rd_i),
    .rd1_idx  (rs1_addr_i),
    .rd2_idx  (rs2_addr_i),
    .rd1_busy (rs1_busy_c),
    .rd2_busy (rs2_busy_c),
    .busy     (busy_o)
  );

  // IF/ID register; contents are kept when the slot empties so decode sees stable bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_q <= 1'b0;
      slot_q     <= '{ins: INST_NOP, addr: '0};
    end else if (jump_i) begin
      id_valid_q <= 1'b0;
    end else if (load_c) begin
      id_valid_q <= 1'b1;
      slot_q     <= '{ins: ins_i, addr: ins_addr_i};
    end else if (issue_c) begin
      id_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PC_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Redirect dominates; the flush exit cycle (count already zero) still discards fetch.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (jump_i) begin
      state_d     = PC_FLUSH;
      flush_cnt_d = FLUSH_LOAD;
    end else begin
      case (state_q)
        PC_RUN:   if (id_valid_q && !issue_c) state_d = PC_STALL;
        PC_STALL: if (issue_c) state_d = PC_RUN;
        PC_FLUSH: begin
          if (flush_cnt_q == '0) state_d = PC_RUN;
          else                   flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
        end
        default:  state_d = PC_RUN;
      endcase
    end
  end

  // Only scoreboard hazards are counted; back-pressure from execute is not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (hazard_c && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign if_ready_o    = if_ready_c;
  assign issue_o       = issue_c;
  assign id_valid_o    = id_valid_q;
  assign id_ins_o      = slot_q.ins;
  assign id_ins_addr_o = slot_q.addr;
  assign state_o       = state_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule
